// File: rtl/module_biquad_iir.sv
// Direct-form-I biquad low-pass filter. The five products of each output sample are
// issued one per cycle to a shared DSP slice and accumulated as they return.
module module_biquad_iir #(
    parameter int DSP_LAT = 2,
    parameter int ACC_W   = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [89:0] coefs_flat,
    input  logic        coefs_valid,
    input  logic [17:0] sample_in,
    input  logic        sample_in_valid,
    output logic        sample_in_ready,
    output logic [17:0] sample_out,
    output logic        sample_out_valid,
    input  logic [83:0] dsp_outs_flat,
    output logic [91:0] dsp_ins_flat,
    output logic [1:0]  dbg_state
);

    // Handshake: a sample is taken on any edge where sample_in_valid and sample_in_ready
    // are both high; ready is high only in IDLE, and a valid while not ready is dropped.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [89:0]        coef_act_q, coef_act_d;
    logic [89:0]        coef_pend_q, coef_pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [17:0]        x_q, x_d;
    logic [17:0]        x1_q, x1_d;
    logic [17:0]        x2_q, x2_d;
    logic [17:0]        y1_q, y1_d;
    logic [17:0]        y2_q, y2_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DSP_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [DSP_LAT-1:0] pipe_sub_q, pipe_sub_d;
    logic [17:0]        sample_out_q, sample_out_d;
    logic               out_valid_q, out_valid_d;
    logic               ready_q, ready_d;
    logic [91:0]        dsp_ins_q, dsp_ins_d;

    logic [35:0]        m_raw;
    logic [ACC_W-1:0]   term;
    logic [17:0]        y_sat;
    logic [17:0]        a_sel;
    logic [17:0]        b_sel;
    logic               unused_p;

    assign m_raw    = dsp_outs_flat[83:48];
    assign term     = {{(ACC_W-36){m_raw[35]}}, m_raw};
    assign unused_p = ^dsp_outs_flat[47:0];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        coef_act_d   = coef_act_q;
        coef_pend_d  = coef_pend_q;
        pend_flag_d  = pend_flag_q;
        x_d          = x_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        acc_d        = acc_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        dsp_ins_d    = '0;
        a_sel        = '0;
        b_sel        = '0;
        y_sat        = '0;

        if (coefs_valid) begin
            coef_pend_d = coefs_flat;
            pend_flag_d = 1'b1;
        end

        // Tag pipeline mirrors the DSP latency so each returning m is matched to its issue.
        pipe_vld_d[0] = (state_q == S_ISSUE);
        pipe_sub_d[0] = (state_q == S_ISSUE) && (cnt_q == 4'd4);
        for (int i = 1; i < DSP_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_sub_d[i] = pipe_sub_q[i-1];
        end

        if (pipe_vld_q[DSP_LAT-1]) begin
            acc_d = pipe_sub_q[DSP_LAT-1] ? (acc_q - term) : (acc_q + term);
        end

        // acc is Q.32; the Q2.16 result fits only when bits above 33 all match the sign.
        if ((&acc_d[ACC_W-1:33]) || !(|acc_d[ACC_W-1:33])) begin
            y_sat = acc_d[33:16];
        end else begin
            y_sat = acc_d[ACC_W-1] ? 18'h20000 : 18'h1FFFF;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_in_valid) begin
                    x_d     = sample_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                    if (coefs_valid) begin
                        coef_act_d = coefs_flat;
                    end else if (pend_flag_q) begin
                        coef_act_d  = coef_pend_q;
                        pend_flag_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == 4'd4) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'(DSP_LAT - 1)) begin
                    state_d      = S_OUT;
                    out_valid_d  = 1'b1;
                    sample_out_d = y_sat;
                    x2_d         = x1_q;
                    x1_d         = x_q;
                    y2_d         = y1_q;
                    y1_d         = y_sat;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);

        // Operands are registered, so they are chosen from next-cycle state and coefs.
        if (state_d == S_ISSUE) begin
            case (cnt_d)
                4'd0: begin a_sel = coef_act_d[53:36]; b_sel = x_d;  end
                4'd1: begin a_sel = coef_act_d[35:18]; b_sel = x1_q; end
                4'd2: begin a_sel = coef_act_d[17:0];  b_sel = x2_q; end
                4'd3: begin a_sel = coef_act_d[89:72]; b_sel = y1_q; end
                4'd4: begin a_sel = coef_act_d[71:54]; b_sel = y2_q; end
                default: begin a_sel = '0; b_sel = '0; end
            endcase
            dsp_ins_d = {8'h00, a_sel, b_sel, 48'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            coef_act_q   <= '0;
            coef_pend_q  <= '0;
            pend_flag_q  <= 1'b0;
            x_q          <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            acc_q        <= '0;
            pipe_vld_q   <= '0;
            pipe_sub_q   <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            ready_q      <= 1'b1;
            dsp_ins_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            coef_act_q   <= coef_act_d;
            coef_pend_q  <= coef_pend_d;
            pend_flag_q  <= pend_flag_d;
            x_q          <= x_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            acc_q        <= acc_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_sub_q   <= pipe_sub_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            ready_q      <= ready_d;
            dsp_ins_q    <= dsp_ins_d;
        end
    end

    assign sample_in_ready  = ready_q;
    assign sample_out       = sample_out_q;
    assign sample_out_valid = out_valid_q;
    assign dsp_ins_flat     = dsp_ins_q;
    assign dbg_state        = state_q;

endmodule
